// File: rtl/usr_sequencer_if.sv
// Command/response channel between a word-level requester and usr_sequencer.
// Both channels use valid/ready handshakes; a beat transfers on valid & ready.
// master = requester side, slave = sequencer side.
interface usr_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/usr_sequencer.sv
// Purpose: turns one command into a WIDTH-bit serialize/deserialize sequence on a universal shift register.
// Latency: rsp_valid WIDTH+2 cycles after accept for TX, WIDTH+1 for RX; one command in flight.
// Backpressure: cmd_ready only in IDLE; DONE holds until rsp_ready. Optional USR_SEQ_STALL_EN adds ser_stall to freeze SHIFT.
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    usr_sequencer_if.slave   req,
    output logic             ser_out,
    output logic             ser_out_valid,
    input  logic             ser_in,
    output logic             ser_in_ready,
    output logic             busy,
    output logic [1:0]       sr_control,
    output logic [WIDTH-1:0] sr_data_in,
    output logic             sr_si_left,
    output logic             sr_si_right,
    input  logic [WIDTH-1:0] sr_q
`ifdef USR_SEQ_STALL_EN
    ,
    input  logic             ser_stall
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    // Shift register control encodings
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHR  = 2'b01;  // {si_left, q[W-1:1]}
    localparam logic [1:0] SR_SHL  = 2'b10;  // {q[W-2:0], si_right}
    localparam logic [1:0] SR_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] bit_cnt_q;

    logic stall;
    logic shift_right;

`ifdef USR_SEQ_STALL_EN
    assign stall = ser_stall;
`else
    assign stall = 1'b0;
`endif

    // TX_LSB (00) and RX_LSB (11) shift towards the LSB; the MSB ops shift towards the MSB.
    assign shift_right = ~(op_q[1] ^ op_q[0]);

    // Sequencer state, latched command and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req.cmd_valid) begin
                        op_q      <= req.cmd_op;
                        data_q    <= req.cmd_data;
                        bit_cnt_q <= '0;
                        // RX needs no preload: the received bits overwrite the register.
                        state_q   <= req.cmd_op[1] ? SHIFT : LOAD;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!stall) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (req.rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode from state and latched op; unused serial-in pins stay 0
    always_comb begin
        req.cmd_ready = (state_q == IDLE);
        req.rsp_valid = (state_q == DONE);
        req.rsp_data  = (state_q == DONE) ? sr_q : '0;
        busy          = (state_q != IDLE);
        sr_control    = SR_HOLD;
        sr_data_in    = '0;
        sr_si_left    = 1'b0;
        sr_si_right   = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        ser_in_ready  = 1'b0;
        case (state_q)
            LOAD: begin
                sr_control = SR_LOAD;
                sr_data_in = data_q;
            end
            SHIFT: begin
                if (!stall) begin
                    sr_control = shift_right ? SR_SHR : SR_SHL;
                    if (op_q[1]) begin
                        ser_in_ready = 1'b1;
                        if (shift_right) begin
                            sr_si_left = ser_in;
                        end else begin
                            sr_si_right = ser_in;
                        end
                    end else begin
                        ser_out_valid = 1'b1;
                        ser_out       = shift_right ? sr_q[0] : sr_q[WIDTH-1];
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer with a behavioural universal shift register attached.
// Each command is driven and checked at the falling edge; expected values are hand-computed.
// Build with USR_SEQ_STALL_EN defined to also run the stall scenario.
module tb_usr_sequencer;

    localparam int W = 4;

    localparam logic [1:0] OP_TX_LSB = 2'b00;
    localparam logic [1:0] OP_TX_MSB = 2'b01;
    localparam logic [1:0] OP_RX_MSB = 2'b10;
    localparam logic [1:0] OP_RX_LSB = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_out, ser_out_valid, ser_in, ser_in_ready, busy;
    logic [1:0]   sr_control;
    logic [W-1:0] sr_data_in;
    logic         sr_si_left, sr_si_right;
    logic [W-1:0] sr_q = '0;
    logic         ser_stall;

    int n_chk  = 0;
    int n_pass = 0;

    usr_sequencer_if #(.WIDTH(W)) bus ();

    usr_sequencer #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (bus.slave),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .ser_in        (ser_in),
        .ser_in_ready  (ser_in_ready),
        .busy          (busy),
        .sr_control    (sr_control),
        .sr_data_in    (sr_data_in),
        .sr_si_left    (sr_si_left),
        .sr_si_right   (sr_si_right),
        .sr_q          (sr_q)
`ifdef USR_SEQ_STALL_EN
        ,
        .ser_stall     (ser_stall)
`endif
    );

    always #5 clk = ~clk;

    // Universal shift register driven by the sequencer (never reset by it)
    always @(posedge clk) begin
        case (sr_control)
            2'b01:   sr_q <= {sr_si_left, sr_q[W-1:1]};
            2'b10:   sr_q <= {sr_q[W-2:0], sr_si_right};
            2'b11:   sr_q <= sr_data_in;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One full command. Serial sequences are packed first-bit-in-MSB.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] data,
                           input logic [W-1:0] rx_bits, input logic [W-1:0] exp_ser,
                           input logic [W-1:0] exp_rsp, input int exp_lat, input int hold,
                           input int stall_after, input int stall_len);
        int nbits, busy_cnt, lat, stall_left;
        logic [W-1:0] seq;
        nbits = 0; busy_cnt = 0; lat = 0; seq = '0; stall_left = stall_len;
        @(negedge clk); #1;
        chk({tag, "_idle_rdy"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0; bus.cmd_data = '0;
            if (nbits == stall_after && stall_left > 0) begin
                ser_stall = 1'b1; stall_left--;
            end else begin
                ser_stall = 1'b0;
            end
            #1;
            if (busy) busy_cnt++;
            if (c == 1 && !op[1]) chk({tag, "_load"}, {sr_control, sr_data_in}, {2'b11, data});
            if (ser_stall) chk({tag, "_stall_out"}, {ser_out_valid, ser_in_ready, sr_control}, 0);
            if (ser_out_valid) begin seq = {seq[W-2:0], ser_out}; nbits++; end
            if (ser_in_ready && nbits < W) begin ser_in = rx_bits[W-1-nbits]; nbits++; end
            if (bus.rsp_valid) lat = c;
        end
        ser_in = 1'b0; ser_stall = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, "_rsp_data"}, bus.rsp_data, exp_rsp);
        if (!op[1]) chk({tag, "_ser_bits"}, seq, exp_ser);
        // A competing command offered while DONE must be ignored.
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_RX_LSB;
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_vld"}, bus.rsp_valid, 1);
            chk({tag, "_hold_dat"}, bus.rsp_data, exp_rsp);
            chk({tag, "_hold_ctl"}, {bus.cmd_ready, sr_control}, 0);
            @(negedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        chk({tag, "_hs_cmd_rdy"}, bus.cmd_ready, 0);
        @(negedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_after_hs"}, {busy, bus.rsp_valid, bus.cmd_ready}, 3'b001);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ser_in = 1'b0; ser_stall = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
        #12;
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_outs", {bus.rsp_valid, ser_out_valid, ser_in_ready, busy, sr_control}, 0);
        chk("reset_sr_data_in", sr_data_in, 0);
        @(negedge clk); rst = 1'b0;

        run_cmd("tx_lsb", OP_TX_LSB, 4'b1011, 4'b0000, 4'b1101, 4'b0000, 6, 0, 99, 0);
        run_cmd("tx_msb", OP_TX_MSB, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 6, 0, 99, 0);
        run_cmd("rx_msb", OP_RX_MSB, 4'b0000, 4'b1001, 4'b0000, 4'b1001, 5, 0, 99, 0);
        run_cmd("rx_lsb", OP_RX_LSB, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 5, 0, 99, 0);
        run_cmd("rsp_hold", OP_RX_MSB, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 5, 5, 99, 0);

        // Async reset while TX is at bit_cnt 2 (cycle 4 after accept)
        @(negedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_TX_LSB; bus.cmd_data = 4'b1011;
        @(negedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_shifting", {busy, ser_out_valid, sr_control}, 4'b1101);
        rst = 1'b1; #1;
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_outs", {busy, sr_control, ser_out_valid}, 0);
        @(negedge clk); rst = 1'b0;
        run_cmd("post_rst_tx", OP_TX_MSB, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 6, 0, 99, 0);

`ifdef USR_SEQ_STALL_EN
        run_cmd("tx_stall", OP_TX_LSB, 4'b1011, 4'b0000, 4'b1101, 4'b0000, 9, 0, 2, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/usr_sequencer.md
Name: usr_sequencer

Overview:
- Command-driven controller for the team's universal shift register (hold / shift-right / shift-left / parallel-load).
- Turns one accepted command into a full serialize (TX) or deserialize (RX) sequence by driving the register's control, parallel-load and serial-in pins.
- Sits between a word-level requester (valid/ready command and response channels) and a 1-bit serial link.

Parameters:
- WIDTH, 4: shift register width and bits per transfer (>=2).
- CNT_W, $clog2(WIDTH)+1: bit counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 TX_LSB, 01 TX_MSB, 10 RX_MSB, 11 RX_LSB.
- cmd_data  in  WIDTH  TX word; ignored for RX.
- rsp_valid  out  1  transfer finished.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  sr_q while rsp_valid is high.
- ser_out  out  1  TX serial bit.
- ser_out_valid  out  1  ser_out is meaningful this cycle.
- ser_in  in  1  RX serial bit, sampled on edges where ser_in_ready is high.
- ser_in_ready  out  1  RX shift cycle.
- busy  out  1  state != IDLE.
- sr_control  out  2  to shift register: 00 hold, 01 {si_left,q[W-1:1]}, 10 {q[W-2:0],si_right}, 11 load.
- sr_data_in  out  WIDTH  load value.
- sr_si_left  out  1  serial-in feeding the MSB.
- sr_si_right  out  1  serial-in feeding the LSB.
- sr_q  in  WIDTH  shift register output.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Registered: state, op_r, data_r, bit_cnt. All other outputs are combinational decode of state/op_r.
- Reset (async): state=IDLE, op_r=0, data_r=0, bit_cnt=0. Result: cmd_ready=1; rsp_valid, ser_out_valid, ser_in_ready, busy, sr_control all 0; sr_data_in=0.
- IDLE:
  - sr_control=00.
  - On cmd_valid&cmd_ready: latch op/data.
  - Next state is LOAD for TX ops, SHIFT for RX ops; bit_cnt=0.
- LOAD (1 cycle): sr_control=11, sr_data_in=data_r; next SHIFT.
- SHIFT (exactly WIDTH cycles; bit_cnt 0..WIDTH-1, increments each cycle):
  - TX_LSB: sr_control=01, sr_si_left=0, ser_out=sr_q[0].
  - TX_MSB: sr_control=10, sr_si_right=0, ser_out=sr_q[WIDTH-1].
  - ser_out_valid=1 for both TX ops.
  - RX_MSB: sr_control=10, sr_si_right=ser_in; first received bit ends in the MSB.
  - RX_LSB: sr_control=01, sr_si_left=ser_in; first received bit ends in the LSB.
  - ser_in_ready=1 for both RX ops.
  - When bit_cnt==WIDTH-1: next state DONE, bit_cnt cleared.
- DONE:
  - sr_control=00; rsp_valid=1; rsp_data=sr_q (TX leaves zeros, RX leaves the received word).
  - Stays in DONE while rsp_ready=0.
  - rsp_valid&rsp_ready returns to IDLE; the next command is accepted no earlier than the following cycle.
- Unused serial-in pins are driven 0. sr_data_in equals data_r only in LOAD, else 0.
- Latency from the accept edge:
  - TX: rsp_valid at cycle WIDTH+2.
  - RX: rsp_valid at cycle WIDTH+1.
- Simultaneous events: cmd_valid during a non-IDLE state is ignored; the requester must hold it.
- Reset mid-operation: immediate return to IDLE and sr_control=00. Partial shift-register contents are left as-is and are not cleared by this block.

Optional Feature:
- Macro: USR_SEQ_STALL_EN.
- Defined: adds input ser_stall (1 bit). While ser_stall=1 in SHIFT:
  - sr_control=00; bit_cnt and state hold;
  - ser_out_valid=0 and ser_in_ready=0.
  - A stall never extends LOAD or DONE.
- Undefined: no ser_stall port; SHIFT always advances every cycle.

Test Plan:
- TX_LSB, cmd_data=4'b1011, rsp_ready=1 -> ser_out=1,1,0,1 on 4 consecutive ser_out_valid cycles; rsp_valid at accept+6 with rsp_data=4'b0000.
- TX_MSB, cmd_data=4'b1011 -> ser_out=1,0,1,1; busy high 6 cycles.
- RX_MSB, ser_in=1,0,0,1 -> rsp_data=4'b1001 at accept+5; RX_LSB, ser_in=1,0,0,0 -> rsp_data=4'b0001.
- rsp_ready low 5 cycles in DONE -> rsp_valid and rsp_data stable, cmd_ready=0, sr_control=00; new cmd_valid is not accepted until one cycle after the handshake.
- Assert rst asynchronously at bit_cnt=2 of TX -> same-cycle cmd_ready=1, busy=0, sr_control=00, ser_out_valid=0; the following command completes normally.
- With USR_SEQ_STALL_EN: TX 4'b1011, ser_stall high for 3 cycles after the 2nd bit -> bits 1,1,0,1 still emitted in order; rsp_valid delayed by exactly 3 cycles.
